gshare_branch_predictor: RTL and testbench
==========================================

# gshare_branch_predictor

Parametrised global-history branch predictor for the IF stage of the pipelined RV32I core. It succeeds the fixed-size predictor with a tagged BTB of configurable depth, saturating counters of configurable width and a global history register XOR-hashed into the pattern table. Lookup is combinational on the fetch PC. Resolved outcomes from the ID/EX boundary train it, one clock per update.

## Interface
- INDEX_BITS, 5: log2 of BTB and PHT entries (32 entries); range 2..10
- HIST_BITS, 5: global history length; 1..INDEX_BITS
- COUNTER_BITS, 2: PHT saturating-counter width; 1..4
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; sampled at posedge
- current_pc  in  32  IF-stage fetch PC
- prediction  out  1  1 = predicted taken
- predicted_pc  out  32  next fetch PC
- pred_index  out  INDEX_BITS  PHT index used for this lookup; pipeline carries it to resolution
- update_valid  in  1  one-cycle pulse per resolved control-flow instruction (branch, jal, jalr)
- update_pc  in  32  PC of the resolved instruction
- update_index  in  INDEX_BITS  pred_index captured at that instruction's fetch
- update_taken  in  1  actual outcome
- update_target  in  32  actual target when taken

## Operation
- Fields: idx = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
- State: BTB[2^INDEX_BITS] = {valid, tag, target}; PHT[2^INDEX_BITS] COUNTER_BITS-bit counters; BHR HIST_BITS bits.
- pred_index = idx(current_pc) XOR BHR, with BHR zero-extended into the low bits.
- hit = BTB[idx].valid && BTB[idx].tag == tag(current_pc).
- prediction = hit && PHT[pred_index] MSB.
- predicted_pc = prediction ? BTB[idx].target : current_pc + 4, mod 2^32.
- On update_valid (no reset):
  - PHT[update_index]: +1 if taken, -1 if not; saturates at 0 and 2^COUNTER_BITS-1.
  - If taken: BTB[idx(update_pc)] <= {1, tag(update_pc), update_target}, overwriting any entry. Not-taken leaves the BTB unchanged.
  - BHR <= {BHR[HIST_BITS-2:0], update_taken}. With HIST_BITS=1, BHR <= update_taken.
- The caller guarantees exactly one update_valid pulse per instruction, including across pipeline stalls.
- The predictor does not act on mispredictions; the core flushes and redirects.

## Timing
- Lookup: zero latency, combinational from current_pc and state.
- Update: state changes at the posedge where update_valid=1. Outputs reflect it from the next cycle.
- Lookup and update on the same entry in the same cycle: outputs that cycle show the pre-update state.
- Reset (posedge with reset=1):
  - All BTB valid bits = 0.
  - Every PHT counter = 2^(COUNTER_BITS-1)-1 (weakly not-taken; 01 at default).
  - BHR = 0.
  - Reset overrides a concurrent update_valid; that update is dropped.
  - After reset: prediction=0, predicted_pc=current_pc+4, pred_index=idx(current_pc).
- Reset mid-stream is legal at any cycle. In-flight update_index values are dropped by the core flush.

## Configuration
- BP_GSHARE_EN defined: behaviour as above. BHR is instantiated and hashed into pred_index.
- BP_GSHARE_EN undefined: pure bimodal. No BHR, pred_index = idx(current_pc), HIST_BITS ignored. All other behaviour is unchanged.

## Test plan
- Reset, then current_pc=0x40 -> prediction=0, predicted_pc=0x44, pred_index=16.
- Bimodal (macro off): one update, pc=0x40, idx 16, taken, target=0x100 -> next cycle at current_pc=0x40: prediction=1, predicted_pc=0x100. Gshare (macro on): same update -> BHR=1, current_pc=0x40 gives pred_index=17, prediction=0, predicted_pc=0x44.
- Saturation, macro off, pc=0x40, target 0x100:
  - 4 taken updates -> counter 3.
  - 1st not-taken -> prediction still 1.
  - 2nd not-taken -> prediction=0, predicted_pc=0x44.
  - 3 further not-taken -> counter stays 0, no underflow to 3.
- Tag alias: train pc=0x40 taken to 0x100, then current_pc=0x840 (idx 16, different tag) -> prediction=0, predicted_pc=0x844.
- Same-cycle hazard: current_pc=0x40 while a taken update for 0x40 is applied -> that cycle prediction=0; next cycle (macro off) prediction=1.
- Reset with update_valid=1 on a trained entry -> that update has no effect; next cycle prediction=0 for 0x40, BHR=0, all counters at 1.

Source files
------------

// File: rtl/gshare_branch_predictor.sv
// ---------------------------------------------------------------------------
// gshare_branch_predictor
//
// Purpose:
//   IF-stage branch predictor for the pipelined RV32I core. It combines a
//   tagged, direct-mapped BTB with a table of saturating counters (PHT).
//   Lookup is combinational on the fetch PC. Resolved control-flow outcomes
//   train the tables one update per clock.
//
// Optional feature macro:
//   BP_GSHARE_EN  defined   -> a global history register (BHR) is built and
//                              XOR-hashed into the PHT index (gshare).
//                 undefined -> pure bimodal: PHT index = fetch-PC index,
//                              and HIST_BITS has no effect.
//
// Parameters:
//   INDEX_BITS    log2 of BTB/PHT entries (2..10)
//   HIST_BITS     global history length (1..INDEX_BITS)
//   COUNTER_BITS  PHT saturating-counter width (1..4)
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   current_pc     in   IF-stage fetch PC
//   prediction     out  1 = predicted taken (combinational)
//   predicted_pc   out  next fetch PC (combinational)
//   pred_index     out  PHT index used by this lookup (combinational)
//   update_valid   in   one-cycle pulse per resolved control-flow instruction
//   update_pc      in   PC of the resolved instruction
//   update_index   in   pred_index captured when that instruction was fetched
//   update_taken   in   actual outcome
//   update_target  in   actual target when taken
// ---------------------------------------------------------------------------
module gshare_branch_predictor #(
    parameter int unsigned INDEX_BITS   = 5,
    parameter int unsigned HIST_BITS    = 5,
    parameter int unsigned COUNTER_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           current_pc,
    output logic                  prediction,
    output logic [31:0]           predicted_pc,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken,
    input  logic [31:0]           update_target
);

    localparam int unsigned ENTRIES  = 32'(1) << INDEX_BITS;
    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

    // Counter limits; reset value is "weakly not-taken" (MSB clear, all others set).
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_MIN  = '0;
    localparam logic [COUNTER_BITS-1:0] CNT_INIT =
        COUNTER_BITS'((32'(1) << (COUNTER_BITS - 1)) - 32'(1));

    // Elaboration-time parameter range checks.
    if (INDEX_BITS < 2 || INDEX_BITS > 10) begin : g_bad_index_bits
        $error("gshare_branch_predictor: INDEX_BITS out of range 2..10");
    end
    if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_hist_bits
        $error("gshare_branch_predictor: HIST_BITS out of range 1..INDEX_BITS");
    end
    if (COUNTER_BITS < 1 || COUNTER_BITS > 4) begin : g_bad_counter_bits
        $error("gshare_branch_predictor: COUNTER_BITS out of range 1..4");
    end

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [31:0]         target;
    } btb_entry_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    btb_entry_t              btb_q [ENTRIES];
    btb_entry_t              btb_d [ENTRIES];
    logic [COUNTER_BITS-1:0] pht_q [ENTRIES];
    logic [COUNTER_BITS-1:0] pht_d [ENTRIES];

    // History contribution to the PHT index (zero in bimodal builds).
    logic [INDEX_BITS-1:0]   hist_idx;

    // -----------------------------------------------------------------------
    // Address field extraction
    // -----------------------------------------------------------------------
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;

    assign lk_idx = current_pc[INDEX_BITS+1:2];
    assign lk_tag = current_pc[31:INDEX_BITS+2];
    assign up_idx = update_pc[INDEX_BITS+1:2];
    assign up_tag = update_pc[31:INDEX_BITS+2];

    // Instruction-aligned PCs: the two low bits carry no information here.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{current_pc[1:0], update_pc[1:0]};

`ifdef BP_GSHARE_EN
    // -----------------------------------------------------------------------
    // Global history register
    // -----------------------------------------------------------------------
    logic [HIST_BITS-1:0] bhr_q;
    logic [HIST_BITS-1:0] bhr_d;

    // Shift the newest outcome in at bit 0; the truncating cast drops the
    // oldest bit and also covers HIST_BITS == 1.
    always_comb begin
        bhr_d = bhr_q;
        if (update_valid) begin
            bhr_d = HIST_BITS'({bhr_q, update_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bhr_q <= '0;
        end else begin
            bhr_q <= bhr_d;
        end
    end

    // History occupies the low bits of the index, zero-extended.
    assign hist_idx = INDEX_BITS'(bhr_q);
`else
    assign hist_idx = '0;
`endif

    // -----------------------------------------------------------------------
    // Lookup (combinational, always sees pre-update state)
    // -----------------------------------------------------------------------
    btb_entry_t lk_entry;
    logic       lk_hit;
    logic       lk_dir;

    assign pred_index   = lk_idx ^ hist_idx;
    assign lk_entry     = btb_q[lk_idx];
    assign lk_hit       = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign lk_dir       = pht_q[pred_index][COUNTER_BITS-1];
    assign prediction   = lk_hit && lk_dir;
    assign predicted_pc = prediction ? lk_entry.target : (current_pc + 32'd4);

    // -----------------------------------------------------------------------
    // PHT next state: saturating increment on taken, decrement on not-taken
    // -----------------------------------------------------------------------
    always_comb begin
        pht_d = pht_q;
        if (update_valid) begin
            if (update_taken) begin
                if (pht_q[update_index] != CNT_MAX) begin
                    pht_d[update_index] = pht_q[update_index] + COUNTER_BITS'(1);
                end
            end else begin
                if (pht_q[update_index] != CNT_MIN) begin
                    pht_d[update_index] = pht_q[update_index] - COUNTER_BITS'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // BTB next state: only taken outcomes allocate, overwriting any entry
    // -----------------------------------------------------------------------
    always_comb begin
        btb_d = btb_q;
        if (update_valid && update_taken) begin
            btb_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: update_target};
        end
    end

    // -----------------------------------------------------------------------
    // Table registers; reset wins over a concurrent update
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= CNT_INIT;
                btb_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= pht_d[i];
                btb_q[i] <= btb_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

    localparam int unsigned IB  = 5;
    localparam int unsigned HB  = 5;
    localparam int unsigned CB  = 2;
    localparam int unsigned NUM = 1 << IB;
`ifdef BP_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [31:0]   current_pc;
    logic          prediction;
    logic [31:0]   predicted_pc;
    logic [IB-1:0] pred_index;
    logic          update_valid;
    logic [31:0]   update_pc;
    logic [IB-1:0] update_index;
    logic          update_taken;
    logic [31:0]   update_target;

    gshare_branch_predictor #(
        .INDEX_BITS   (IB),
        .HIST_BITS    (HB),
        .COUNTER_BITS (CB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .current_pc    (current_pc),
        .prediction    (prediction),
        .predicted_pc  (predicted_pc),
        .pred_index    (pred_index),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_index  (update_index),
        .update_taken  (update_taken),
        .update_target (update_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers and arrays
    int unsigned m_cnt [NUM];
    bit          m_val [NUM];
    int unsigned m_tag [NUM];
    int unsigned m_tgt [NUM];
    int unsigned m_bhr;

    typedef struct {
        bit            p;
        logic [31:0]   npc;
        logic [IB-1:0] idx;
    } exp_t;

    exp_t exp_q [$];
    bit   chk_valid;
    int   n_checks;
    int   n_fail;

    function automatic exp_t model_lookup(input int unsigned pc);
        exp_t        e;
        int unsigned i;
        int unsigned t;
        int unsigned g;
        bit          hit;
        i   = (pc >> 2) % NUM;
        t   = pc >> (IB + 2);
        g   = GSHARE ? (i ^ m_bhr) : i;
        hit = m_val[i] && (m_tag[i] == t);
        e.p   = hit && (m_cnt[g] >= (1 << (CB - 1)));
        e.npc = e.p ? m_tgt[i] : (pc + 4);
        e.idx = IB'(g);
        return e;
    endfunction

    task automatic model_apply(input bit rst, input bit uv, input int unsigned upc,
                               input int unsigned uidx, input bit ut,
                               input int unsigned utgt);
        int unsigned i;
        if (rst) begin
            for (int k = 0; k < NUM; k++) begin
                m_val[k] = 1'b0;
                m_cnt[k] = (1 << (CB - 1)) - 1;
            end
            m_bhr = 0;
        end else if (uv) begin
            if (ut) begin
                if (m_cnt[uidx] < (1 << CB) - 1) m_cnt[uidx] = m_cnt[uidx] + 1;
                i = (upc >> 2) % NUM;
                m_val[i] = 1'b1;
                m_tag[i] = upc >> (IB + 2);
                m_tgt[i] = utgt;
            end else begin
                if (m_cnt[uidx] > 0) m_cnt[uidx] = m_cnt[uidx] - 1;
            end
            m_bhr = ((m_bhr << 1) | (ut ? 1 : 0)) % (1 << HB);
        end
    endtask

    // One cycle of stimulus; expected lookup result is queued before the
    // model absorbs this cycle's update, matching the pre-update view.
    task automatic step(input bit rst, input logic [31:0] pc, input bit uv,
                        input logic [31:0] upc, input int unsigned uidx,
                        input bit ut, input logic [31:0] utgt, input bit chk);
        @(posedge clk);
        #1;
        reset         = rst;
        current_pc    = pc;
        update_valid  = uv;
        update_pc     = upc;
        update_index  = IB'(uidx);
        update_taken  = ut;
        update_target = utgt;
        if (chk) exp_q.push_back(model_lookup(pc));
        chk_valid = chk;
        model_apply(rst, uv, upc, uidx, ut, utgt);
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b0, pc, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] upc,
                         input bit ut, input logic [31:0] utgt);
        step(1'b0, pc, 1'b1, upc, (upc >> 2) % NUM, ut, utgt, 1'b1);
    endtask

    // Monitor: compares DUT outputs mid-cycle against queued expectations
    always @(negedge clk) begin
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: output presented with no expected entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (prediction !== e.p) begin
                    n_fail++;
                    $display("FAIL prediction pc=%h: got %0b expected %0b", current_pc, prediction, e.p);
                end
                n_checks++;
                if (predicted_pc !== e.npc) begin
                    n_fail++;
                    $display("FAIL predicted_pc pc=%h: got %h expected %h", current_pc, predicted_pc, e.npc);
                end
                n_checks++;
                if (pred_index !== e.idx) begin
                    n_fail++;
                    $display("FAIL pred_index pc=%h: got %0d expected %0d", current_pc, pred_index, e.idx);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        n_checks = 0;
        n_fail   = 0;
        chk_valid = 1'b0;
        reset = 1'b1;
        current_pc = 32'h0;
        update_valid = 1'b0;
        update_pc = 32'h0;
        update_index = '0;
        update_taken = 1'b0;
        update_target = 32'h0;

        // Reset and post-reset lookup
        step(1'b1, 32'h40, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        for (int k = 0; k < NUM; k++) look(32'($urandom_range(0, 7)) << (IB + 2) | 32'(k << 2));

        // Same-cycle hazard, then trained lookup and tag alias
        train(32'h40, 32'h40, 1'b1, 32'h100);
        look(32'h40);
        look(32'h840);

        // Saturation up and down
        step(1'b1, 32'h40, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) train(32'h40, 32'h40, 1'b1, 32'h100);
        look(32'h40);
        for (int k = 0; k < 5; k++) begin
            train(32'h40, 32'h40, 1'b0, 32'h0);
            look(32'h40);
        end
        train(32'h40, 32'h40, 1'b1, 32'h100);
        look(32'h40);

        // Reset overrides a concurrent update on a trained entry
        for (int k = 0; k < 3; k++) train(32'h40, 32'h40, 1'b1, 32'h100);
        step(1'b1, 32'h40, 1'b1, 32'h40, 16, 1'b1, 32'h100, 1'b1);
        look(32'h40);

        // Randomized traffic with occasional mid-stream reset
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] pc;
            logic [31:0] upc;
            bit rst;
            bit uv;
            pc  = (32'($urandom_range(0, 3)) << (IB + 2)) | (32'($urandom_range(0, NUM - 1)) << 2);
            upc = (32'($urandom_range(0, 3)) << (IB + 2)) | (32'($urandom_range(0, NUM - 1)) << 2);
            rst = ($urandom_range(0, 99) < 2);
            uv  = ($urandom_range(0, 99) < 60);
            step(rst, pc, uv, upc, $urandom_range(0, NUM - 1), 1'($urandom_range(0, 1)),
                 $urandom & 32'hFFFF_FFFC, 1'b1);
        end

        step(1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
